// File: rtl/pong_score_keeper.sv
// Pong score keeper: per-player scores, the serve delay after each goal and game-over detection.
// Optional build macro PONG_SCORE_BLINK_EN adds score-digit blinking through score_blank.
module pong_score_keeper #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       new_game,
    input  logic       goal_p0,
    input  logic       goal_p1,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic       score_blank
);

    typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, GAME_OVER} state_t;

    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

    state_t     state;
    logic [7:0] frame_cnt;
    logic [3:0] next_score;

`ifdef PONG_SCORE_BLINK_EN
    logic       after_goal;
    logic [3:0] blink_cnt;
`endif

    // The score of whichever player just scored, one higher; only used when exactly one goal fires.
    always_comb begin
        next_score = (goal_p1 ? score1 : score0) + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= 8'd0;
            score0    <= 4'd0;
            score1    <= 4'd0;
            serve     <= 1'b0;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
`ifdef PONG_SCORE_BLINK_EN
            score_blank <= 1'b0;
            after_goal  <= 1'b0;
            blink_cnt   <= 4'd0;
`endif
        end else begin
            serve <= 1'b0;
            if (new_game) begin
                state     <= SERVE_WAIT;
                frame_cnt <= HOLD;
                score0    <= 4'd0;
                score1    <= 4'd0;
                serve_dir <= 1'b0;
                game_over <= 1'b0;
                winner    <= 1'b0;
`ifdef PONG_SCORE_BLINK_EN
                score_blank <= 1'b0;
                after_goal  <= 1'b0;
                blink_cnt   <= 4'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SERVE_WAIT: begin
                        if (frame_tick) begin
                            frame_cnt <= frame_cnt - 8'd1;
`ifdef PONG_SCORE_BLINK_EN
                            if (after_goal) begin
                                blink_cnt <= blink_cnt + 4'd1;
                                if (blink_cnt[2:0] == 3'd7) score_blank <= ~score_blank;
                            end
`endif
                            if (frame_cnt == 8'd1) begin
                                serve <= 1'b1;
                                state <= PLAY;
`ifdef PONG_SCORE_BLINK_EN
                                score_blank <= 1'b0;
`endif
                            end
                        end
                    end
                    PLAY: begin
                        // Simultaneous goals cancel out and play continues.
                        if (goal_p0 != goal_p1) begin
                            if (goal_p1) score1 <= next_score;
                            else         score0 <= next_score;
                            if (next_score >= WIN) begin
                                state     <= GAME_OVER;
                                game_over <= 1'b1;
                                winner    <= goal_p1;
`ifdef PONG_SCORE_BLINK_EN
                                score_blank <= 1'b1;
                                blink_cnt   <= 4'd0;
`endif
                            end else begin
                                state     <= SERVE_WAIT;
                                frame_cnt <= HOLD;
                                serve_dir <= goal_p0;
`ifdef PONG_SCORE_BLINK_EN
                                score_blank <= 1'b0;
                                after_goal  <= 1'b1;
                                blink_cnt   <= 4'd0;
`endif
                            end
                        end
                    end
                    GAME_OVER: begin
`ifdef PONG_SCORE_BLINK_EN
                        if (frame_tick) begin
                            blink_cnt <= blink_cnt + 4'd1;
                            if (blink_cnt == 4'd15) score_blank <= ~score_blank;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef PONG_SCORE_BLINK_EN
    assign score_blank = 1'b0;
`endif

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed scoreboard bench for pong_score_keeper: a default instance (9 / 60) and a short-game instance (3 / 4).
module tb_pong_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       a_tick = 1'b0, a_new = 1'b0, a_g0 = 1'b0, a_g1 = 1'b0;
    logic       b_tick = 1'b0, b_new = 1'b0, b_g0 = 1'b0, b_g1 = 1'b0;
    logic [3:0] a_s0, a_s1, b_s0, b_s1;
    logic       a_serve, a_dir, a_go, a_win, a_blank;
    logic       b_serve, b_dir, b_go, b_win, b_blank;

    pong_score_keeper u_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(a_tick), .new_game(a_new),
        .goal_p0(a_g0), .goal_p1(a_g1), .score0(a_s0), .score1(a_s1),
        .serve(a_serve), .serve_dir(a_dir), .game_over(a_go), .winner(a_win),
        .score_blank(a_blank)
    );

    pong_score_keeper #(.WIN_SCORE(3), .HOLD_FRAMES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(b_tick), .new_game(b_new),
        .goal_p0(b_g0), .goal_p1(b_g1), .score0(b_s0), .score1(b_s1),
        .serve(b_serve), .serve_dir(b_dir), .game_over(b_go), .winner(b_win),
        .score_blank(b_blank)
    );

    // Field order: {score0, score1, serve, serve_dir, game_over, winner, score_blank}
    localparam logic [12:0] M_ALL   = 13'h1fff;
    localparam logic [12:0] M_NOWIN = 13'h1ffd;
    localparam logic [12:0] M_NODIR = 13'h1ff7;

    typedef struct {
        int          sel;
        string       tag;
        logic [12:0] val;
        logic [12:0] mask;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [12:0] obs(input int sel);
        if (sel == 0) return {a_s0, a_s1, a_serve, a_dir, a_go, a_win, a_blank};
        return {b_s0, b_s1, b_serve, b_dir, b_go, b_win, b_blank};
    endfunction

    function automatic logic hold_blank(input int k, input int n);
`ifdef PONG_SCORE_BLINK_EN
        return (k < n) && (((k / 8) % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic over_blank(input int k);
`ifdef PONG_SCORE_BLINK_EN
        return ((k / 16) % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input int sel, input string tag, input logic [3:0] s0, input logic [3:0] s1,
                        input logic sv, input logic dir, input logic go, input logic win,
                        input logic bl, input logic [12:0] mask);
        exp_t e;
        e.sel  = sel;
        e.tag  = tag;
        e.val  = {s0, s1, sv, dir, go, win, bl};
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic drive(input int sel, input logic ng, input logic ft, input logic g0, input logic g1);
        exp_t e;
        logic [12:0] o;
        if (sel == 0) {a_new, a_tick, a_g0, a_g1} = {ng, ft, g0, g1};
        else          {b_new, b_tick, b_g0, b_g1} = {ng, ft, g0, g1};
        @(posedge clk);
        #1;
        {a_new, a_tick, a_g0, a_g1} = 4'b0;
        {b_new, b_tick, b_g0, b_g1} = 4'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            total++;
            assert ((o & e.mask) === (e.val & e.mask)) else begin
                bad++;
                $error("FAIL %s: observed %h required %h (mask %h)", e.tag, o, e.val, e.mask);
            end
        end
    endtask

    task automatic step(input int sel, input logic ng, input logic ft, input logic g0, input logic g1,
                        input string tag, input logic [3:0] s0, input logic [3:0] s1,
                        input logic sv, input logic dir, input logic go, input logic win,
                        input logic bl, input logic [12:0] mask);
        push(sel, tag, s0, s1, sv, dir, go, win, bl, mask);
        drive(sel, ng, ft, g0, g1);
    endtask

    // n ticks of serve hold; the serve pulse must land on tick n and only there.
    task automatic run_hold(input int sel, input int n, input logic [3:0] s0, input logic [3:0] s1,
                            input logic dir, input logic after_goal, input string tag);
        for (int k = 1; k <= n; k++)
            step(sel, 1'b0, 1'b1, 1'b0, 1'b0, tag, s0, s1, k == n, dir, 1'b0, 1'b0,
                 after_goal ? hold_blank(k, n) : 1'b0, M_NOWIN);
        step(sel, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_post"}, s0, s1, 1'b0, dir, 1'b0, 1'b0, 1'b0, M_NOWIN);
    endtask

    initial begin
        push(0, "rst_a", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_ALL);
        push(1, "rst_b", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_ALL);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        step(0, 1, 0, 0, 0, "ng_a", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        run_hold(0, 60, 4'd0, 4'd0, 1'b0, 1'b0, "hold_first");

        step(0, 0, 0, 1, 1, "both_goals", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        for (int k = 0; k < 60; k++)
            step(0, 0, 1, 0, 0, "play_ticks", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        step(0, 0, 0, 0, 1, "goal_p1", 4'd0, 4'd1, 0, 0, 0, 0, 0, M_NOWIN);
        step(0, 0, 0, 1, 0, "wait_goal_p0", 4'd0, 4'd1, 0, 0, 0, 0, 0, M_NOWIN);
        run_hold(0, 60, 4'd0, 4'd1, 1'b0, 1'b1, "hold_p1");

        for (int g = 1; g <= 5; g++) begin
            step(0, 0, 0, 1, 0, "goal_p0", 4'(g), 4'd1, 0, 1, 0, 0, 0, M_NOWIN);
            run_hold(0, 60, 4'(g), 4'd1, 1'b1, 1'b1, "hold_p0");
        end

        rst_n = 1'b0;
        push(0, "mid_rst", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_ALL);
        drive(0, 0, 1, 1, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 0, "idle_goal", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_ALL);
        for (int k = 0; k < 70; k++)
            step(0, 0, 1, 0, 0, "idle_ticks", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_ALL);

        step(0, 1, 0, 0, 0, "ng_again", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        for (int k = 0; k < 30; k++)
            step(0, 0, 1, 0, 0, "partial_wait", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        step(0, 1, 1, 1, 0, "ng_restart", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        run_hold(0, 60, 4'd0, 4'd0, 1'b0, 1'b0, "hold_restart");

        step(1, 1, 0, 0, 0, "b_ng", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        run_hold(1, 4, 4'd0, 4'd0, 1'b0, 1'b0, "b_hold");
        for (int g = 1; g <= 2; g++) begin
            step(1, 0, 0, 1, 0, "b_goal_p0", 4'(g), 4'd0, 0, 1, 0, 0, 0, M_NOWIN);
            run_hold(1, 4, 4'(g), 4'd0, 1'b1, 1'b1, "b_hold_p0");
        end
        step(1, 0, 0, 1, 0, "b_win_p0", 4'd3, 4'd0, 0, 0, 1, 0, over_blank(0), M_NODIR);
        for (int k = 1; k <= 20; k++)
            step(1, 0, 1, (k % 2) == 1, (k % 2) == 0, "b_over_hold", 4'd3, 4'd0, 0, 0, 1, 0,
                 over_blank(k), M_NODIR);

        step(1, 1, 0, 0, 0, "b_ng2", 4'd0, 4'd0, 0, 0, 0, 0, 0, M_NOWIN);
        run_hold(1, 4, 4'd0, 4'd0, 1'b0, 1'b0, "b_hold_ng2");
        for (int g = 1; g <= 2; g++) begin
            step(1, 0, 0, 0, 1, "b_goal_p1", 4'd0, 4'(g), 0, 0, 0, 0, 0, M_NOWIN);
            run_hold(1, 4, 4'd0, 4'(g), 1'b0, 1'b1, "b_hold_p1");
        end
        step(1, 0, 0, 0, 1, "b_win_p1", 4'd0, 4'd3, 0, 0, 1, 1, over_blank(0), M_NODIR);
        step(1, 0, 1, 0, 1, "b_over_p1", 4'd0, 4'd3, 0, 0, 1, 1, over_blank(1), M_NODIR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
